// File: rtl/datamem_pkg.sv
// datamem_pkg
// Shared definitions for the banked data memory:
//   state_t          - controller state encoding (LOAD / RUN / DUMP)
//   DEFAULT_QUAD_MAP - owning bank per result quadrant, 2-bit field at {row_hi,col_hi}
//   res_elem_addr()  - bank address of result element (row, col)
//   res_owner_bank() - bank that owns result element (row, col)
package datamem_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2
    } state_t;

    localparam logic [7:0] DEFAULT_QUAD_MAP = 8'b01_10_11_00;

    // Computed in 32 bits; callers truncate to the bank address width, which
    // gives the required modulo-2^ADDR_W wrap.
    function automatic logic [31:0] res_elem_addr(
        input logic [31:0] row,
        input logic [31:0] col,
        input logic [31:0] base,
        input logic [31:0] stride
    );
        return base + row * stride + col;
    endfunction

    function automatic logic [1:0] res_owner_bank(
        input logic [31:0] row,
        input logic [31:0] col,
        input logic [31:0] n,
        input logic [7:0]  quad_map
    );
        logic [1:0] quad;
        quad = {row >= (n >> 1), col >= (n >> 1)};
        return quad_map[{quad, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/dp_ram_bank.sv
// dp_ram_bank
// One DATA_W x 2^ADDR_W memory bank with two ports.
//   clk, srst      - clock, synchronous active-high reset (clears read registers only)
//   we_a, addr_a, din_a, q_a
//                  - port A: write when we_a, otherwise registered read; q_a holds on write
//   en_b, we_b, addr_b, din_b, q_b
//                  - port B: when en_b, write (we_b) or registered read; q_b holds otherwise
// Reads are read-first: a read and a write to the same address in one cycle
// return the previous contents. Memory contents are never cleared by reset.
module dp_ram_bank #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] q_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] q_b
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
        if (en_b && we_b) begin
            mem[addr_b] <= din_b;
        end

        if (srst) begin
            q_a <= '0;
        end else if (!we_a) begin
            q_a <= mem[addr_a];
        end

        if (srst) begin
            q_b <= '0;
        end else if (en_b && !we_b) begin
            q_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/banked_datamemory.sv
// banked_datamemory
// One private bank per matrix-multiply core, a load port that fills the banks
// before processing, and an optional handshaked dump engine that streams the
// distributed RES_N x RES_N result matrix in row-major order.
// Optional feature macro: BANKED_DMEM_DUMP_EN (dump engine present when defined).
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   write_en, addr, datain, dataout - per-core packed ports, core 0 in LSBs
//   load_valid/ready/bank/addr/data/last - load stream into any bank (LOAD state)
//   start_process                  - high once the final load beat has been accepted
//   dump_req                       - single-cycle request to stream the result matrix
//   dump_valid/ready/data/last     - result stream handshake
module banked_datamemory
    import datamem_pkg::*;
#(
    parameter int         NUM_CORES  = 4,
    parameter int         DATA_W     = 12,
    parameter int         BUS_W      = 17,
    parameter int         ADDR_W     = 12,
    parameter int         RES_N      = 4,
    parameter int         RES_BASE   = 4,
    parameter int         RES_STRIDE = 64,
    parameter logic [7:0] QUAD_MAP   = DEFAULT_QUAD_MAP
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        write_en,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*BUS_W-1:0]  datain,
    output logic [NUM_CORES*DATA_W-1:0] dataout,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [1:0]                  load_bank,
    input  logic [ADDR_W-1:0]           load_addr,
    input  logic [DATA_W-1:0]           load_data,
    input  logic                        load_last,
    output logic                        start_process,
    input  logic                        dump_req,
    output logic                        dump_valid,
    input  logic                        dump_ready,
    output logic [DATA_W-1:0]           dump_data,
    output logic                        dump_last
);

    localparam int CNT_W = (RES_N > 2) ? $clog2(RES_N) : 1;

    state_t state_reg;
    logic   start_reg;
    logic   load_fire;
    logic   core_en;

    // Gating with rst keeps the load port closed during the reset cycle
    // regardless of the state the controller was in.
    assign load_ready    = (state_reg == ST_LOAD) && !rst;
    assign load_fire     = load_valid && load_ready;
    assign core_en       = (state_reg != ST_LOAD) && !rst;
    assign start_process = start_reg;

`ifdef BANKED_DMEM_DUMP_EN
    logic [CNT_W-1:0]  row_reg, col_reg;
    logic              issue_done_reg;
    logic              s1_valid_reg, s1_last_reg;
    logic [1:0]        s1_bank_reg;
    logic              dump_valid_reg, dump_last_reg;
    logic [DATA_W-1:0] dump_data_reg;
    logic [DATA_W-1:0] bank_q_b [NUM_CORES];
    logic              adv, issue, last_elem, dump_done, dump_rd_en;
    logic [ADDR_W-1:0] dump_addr;
    logic [1:0]        issue_bank;

    // The whole read pipeline (address issue, bank read register, output
    // register) advances only when the output register is free or being
    // drained, so bank q_b acts as the stall buffer and nothing is lost.
    assign adv        = !dump_valid_reg || dump_ready;
    assign issue      = (state_reg == ST_DUMP) && !issue_done_reg;
    assign dump_rd_en = (state_reg == ST_DUMP) && adv;
    assign last_elem  = (row_reg == CNT_W'(RES_N - 1)) && (col_reg == CNT_W'(RES_N - 1));
    assign dump_done  = dump_valid_reg && dump_ready && dump_last_reg;
    assign dump_addr  = ADDR_W'(res_elem_addr(32'(row_reg), 32'(col_reg),
                                              32'(RES_BASE), 32'(RES_STRIDE)));
    assign issue_bank = res_owner_bank(32'(row_reg), 32'(col_reg), 32'(RES_N), QUAD_MAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            row_reg        <= '0;
            col_reg        <= '0;
            issue_done_reg <= 1'b0;
            s1_valid_reg   <= 1'b0;
            s1_last_reg    <= 1'b0;
            s1_bank_reg    <= '0;
            dump_valid_reg <= 1'b0;
            dump_last_reg  <= 1'b0;
            dump_data_reg  <= '0;
        end else if (state_reg == ST_RUN && dump_req) begin
            row_reg        <= '0;
            col_reg        <= '0;
            issue_done_reg <= 1'b0;
            s1_valid_reg   <= 1'b0;
            dump_valid_reg <= 1'b0;
            dump_last_reg  <= 1'b0;
        end else if (adv) begin
            s1_valid_reg   <= issue;
            s1_last_reg    <= issue && last_elem;
            s1_bank_reg    <= issue_bank;
            dump_valid_reg <= s1_valid_reg;
            dump_last_reg  <= s1_last_reg;
            if (s1_valid_reg) begin
                dump_data_reg <= bank_q_b[s1_bank_reg];
            end
            if (issue) begin
                if (last_elem) begin
                    issue_done_reg <= 1'b1;
                end else if (col_reg == CNT_W'(RES_N - 1)) begin
                    col_reg <= '0;
                    row_reg <= row_reg + 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end
        end
    end

    assign dump_valid = dump_valid_reg;
    assign dump_data  = dump_data_reg;
    assign dump_last  = dump_last_reg;

    // Only the truncated high bits of each core's write bus are left over.
    logic unused_in;
    assign unused_in = ^datain;
`else
    assign dump_valid = 1'b0;
    assign dump_data  = '0;
    assign dump_last  = 1'b0;

    logic unused_in;
    assign unused_in = ^{datain, dump_req, dump_ready};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_LOAD;
            start_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    if (load_fire && load_last) begin
                        state_reg <= ST_RUN;
                        start_reg <= 1'b1;
                    end
                end
`ifdef BANKED_DMEM_DUMP_EN
                ST_RUN: begin
                    if (dump_req) begin
                        state_reg <= ST_DUMP;
                    end
                end
                ST_DUMP: begin
                    if (dump_done) begin
                        state_reg <= ST_RUN;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_bank
            logic load_we;
            assign load_we = load_fire && (32'(load_bank) == gi);
`ifdef BANKED_DMEM_DUMP_EN
            // Port B is shared: load writes in LOAD, dump reads in DUMP.
            dp_ram_bank #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W)
            ) u_bank (
                .clk    (clk),
                .srst   (rst),
                .we_a   (write_en[gi] && core_en),
                .addr_a (addr[gi*ADDR_W +: ADDR_W]),
                .din_a  (datain[gi*BUS_W +: DATA_W]),
                .q_a    (dataout[gi*DATA_W +: DATA_W]),
                .en_b   (load_we || dump_rd_en),
                .we_b   (load_we),
                .addr_b (load_we ? load_addr : dump_addr),
                .din_b  (load_data),
                .q_b    (bank_q_b[gi])
            );
`else
            logic [DATA_W-1:0] unused_q_b;
            dp_ram_bank #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W)
            ) u_bank (
                .clk    (clk),
                .srst   (rst),
                .we_a   (write_en[gi] && core_en),
                .addr_a (addr[gi*ADDR_W +: ADDR_W]),
                .din_a  (datain[gi*BUS_W +: DATA_W]),
                .q_a    (dataout[gi*DATA_W +: DATA_W]),
                .en_b   (load_we),
                .we_b   (1'b1),
                .addr_b (load_addr),
                .din_b  (load_data),
                .q_b    (unused_q_b)
            );
`endif
        end
    endgenerate

endmodule
